sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the team's fixed-size synchronous FIFO.
- Configurable data width and power-of-two depth, with programmable almost-full/almost-empty thresholds.
- Two read modes: standard registered read or first-word-fall-through (FWFT).
- Sticky overflow/underflow error flags, a synchronous flush, and correct simultaneous read/write handling.
- Sits between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_fifo_param_if.sv | 33 +++
 rtl/fifo_ram.sv | 38 +++
 rtl/sync_fifo_param.sv | 108 ++++++++++
 tb/tb_sync_fifo_param.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

  // Depth must be a power of two so the pointers can wrap by plain overflow.
  function automatic bit thresh_ok(input int unsigned depth,
                                   input int unsigned af,
                                   input int unsigned ae);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port FIFO storage: synchronous write, registered or combinational read.
module fifo_ram import fifo_pkg::*; #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = ptr_w(DEPTH),
  parameter int unsigned REG_RD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_RD != 0) begin : g_reg
      // The read register holds its value between accepted reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_comb
      logic unused_rd;
      assign unused_rd = rst ^ re;
      assign rdata     = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, sticky errors, flush and optional FWFT.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = FIFO_STD
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned ADDR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  generate
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
      $error("sync_fifo_param: DEPTH must be a power of two >= 4 with sane thresholds");
    end
  endgenerate

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              udf;
  logic              full_w;
  logic              empty_w;
  logic              rd_acc;
  logic              wr_acc;
  logic              ram_we;
  logic              ram_re;

  assign full_w  = (cnt == CNT_W'(DEPTH));
  assign empty_w = (cnt == '0);

  // A write into a full FIFO is legal when a read frees a slot on the same edge.
  assign rd_acc = bus.rd_en && !empty_w;
  assign wr_acc = bus.wr_en && (!full_w || rd_acc);
  assign ram_we = wr_acc && !bus.clr;
  assign ram_re = rd_acc && !bus.clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (bus.wr_en && !wr_acc) ovf <= 1'b1;
      if (bus.rd_en && !rd_acc) udf <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .REG_RD ((FWFT == FIFO_FWFT) ? 0 : 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign bus.rd_valid = !empty_w;
    end else begin : g_std
      logic rv_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          rv_q <= 1'b0;
        else if (bus.clr) rv_q <= 1'b0;
        else              rv_q <= rd_acc;
      end
      assign bus.rd_valid = rv_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (cnt <= CNT_W'(AE_THRESH));
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: standard and FWFT instances driven in lockstep against a queue model.
module tb_sync_fifo_param;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned AF  = 14;
  localparam int unsigned AE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEP)) bs_if ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEP)) bf_if ();

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0))
    dut_std (.clk(clk), .rst(rst), .bus(bs_if));
  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1))
    dut_fwft (.clk(clk), .rst(rst), .bus(bf_if));

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy is a queue, read register tracked separately.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_rd;

  typedef struct {
    bit            wr;
    bit            rd;
    logic [DW-1:0] wd;
    int            e_count;
    bit            e_full;
    bit            e_empty;
    bit            e_af;
    bit            e_ovf;
    bit            e_udf;
    bit            e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input bit c, input logic [DW-1:0] d);
    int  n;
    bit  rok, wok;
    if (c) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rv = 0;
    end else begin
      n   = q.size();
      rok = rd && (n > 0);
      wok = wr && ((n < DEP) || rok);
      if (rok) m_rd = q.pop_front();
      m_rv = rok;
      if (wok) q.push_back(d);
      if (wr && !wok) m_ovf = 1;
      if (rd && !rok) m_udf = 1;
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_std",  bs_if.count, n);
    chk("count_fwft", bf_if.count, n);
    chk("full",       bs_if.full, (n == DEP));
    chk("empty",      bs_if.empty, (n == 0));
    chk("almost_full",  bs_if.almost_full, (n >= AF));
    chk("almost_empty", bs_if.almost_empty, (n <= AE));
    chk("overflow_std",   bs_if.overflow, m_ovf);
    chk("underflow_std",  bs_if.underflow, m_udf);
    chk("overflow_fwft",  bf_if.overflow, m_ovf);
    chk("underflow_fwft", bf_if.underflow, m_udf);
    chk("rd_valid_std", bs_if.rd_valid, m_rv);
    chk("rd_data_std",  bs_if.rd_data, m_rd);
    chk("rd_valid_fwft", bf_if.rd_valid, (n > 0));
    if (n > 0) chk("rd_data_fwft", bf_if.rd_data, q[0]);
  endtask

  task automatic drive(input bit wr, input bit rd, input bit c, input logic [DW-1:0] d);
    bs_if.wr_en = wr; bs_if.rd_en = rd; bs_if.clr = c; bs_if.wr_data = d;
    bf_if.wr_en = wr; bf_if.rd_en = rd; bf_if.clr = c; bf_if.wr_data = d;
  endtask

  task automatic cyc(input bit wr, input bit rd, input bit c, input logic [DW-1:0] d);
    drive(wr, rd, c, d);
    @(posedge clk);
    #1;
    model_step(wr, rd, c, d);
    check_all();
  endtask

  initial begin
    vec_t v;
    int   pw, pr;

    // Fill 0x00..0x0F, one rejected write, drain 16, one rejected read.
    for (int i = 0; i < 16; i++) begin
      v = '{1, 0, 8'(i), i + 1, (i == 15), 0, (i >= 13), 0, 0, 0, 8'h00};
      tbl.push_back(v);
    end
    v = '{1, 0, 8'h10, 16, 1, 0, 1, 1, 0, 0, 8'h00};
    tbl.push_back(v);
    for (int j = 0; j < 16; j++) begin
      v = '{0, 1, 8'h00, 15 - j, 0, (j == 15), (j <= 1), 1, 0, 1, 8'(j)};
      tbl.push_back(v);
    end
    v = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 0, 8'h0F};
    tbl.push_back(v);

    drive(0, 0, 0, '0);
    model_reset();
    #1;
    chk("reset_count", bs_if.count, 0);
    chk("reset_empty", bs_if.empty, 1);
    chk("reset_full",  bs_if.full, 0);
    chk("reset_ae",    bs_if.almost_empty, 1);
    chk("reset_af",    bs_if.almost_full, 0);
    chk("reset_rd_data", bs_if.rd_data, 0);
    chk("reset_rd_valid_fwft", bf_if.rd_valid, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    check_all();

    foreach (tbl[k]) begin
      cyc(tbl[k].wr, tbl[k].rd, 0, tbl[k].wd);
      chk("tbl_count", bs_if.count, tbl[k].e_count);
      chk("tbl_full",  bs_if.full, tbl[k].e_full);
      chk("tbl_empty", bs_if.empty, tbl[k].e_empty);
      chk("tbl_af",    bs_if.almost_full, tbl[k].e_af);
      chk("tbl_ovf",   bs_if.overflow, tbl[k].e_ovf);
      chk("tbl_udf",   bs_if.underflow, tbl[k].e_udf);
      chk("tbl_rv",    bs_if.rd_valid, tbl[k].e_rv);
      chk("tbl_rd",    bs_if.rd_data, tbl[k].e_rd);
    end

    // Wrap-around: pointers advance by 10 before the 12-word burst.
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(i));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, '0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 8'(8'hA0 + i));
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, '0);
      chk("wrap_data", bs_if.rd_data, 8'hA0 + i);
    end
    chk("wrap_count", bs_if.count, 0);

    // Simultaneous read/write while full, then while empty.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 8'(8'hB0 + i));
      chk("full_rw_count", bs_if.count, 16);
      chk("full_rw_ovf",   bs_if.overflow, 0);
      chk("full_rw_data",  bs_if.rd_data, 8'h30 + i);
    end
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, '0);
    chk("drain_last", bs_if.rd_data, 8'hB4);
    cyc(1, 1, 0, 8'hC1);
    chk("empty_rw_count", bs_if.count, 1);
    chk("empty_rw_udf",   bs_if.underflow, 1);

    // FWFT: a word into an empty FIFO shows up without rd_en.
    cyc(0, 0, 1, '0);
    cyc(1, 0, 0, 8'h55);
    chk("fwft_valid", bf_if.rd_valid, 1);
    chk("fwft_data",  bf_if.rd_data, 8'h55);
    cyc(0, 1, 0, '0);
    chk("fwft_pop_valid", bf_if.rd_valid, 0);
    chk("fwft_pop_empty", bf_if.empty, 1);

    // Flush with overflow set and seven words held.
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, 8'(8'h60 + i));
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, '0);
    chk("pre_clr_count", bs_if.count, 7);
    chk("pre_clr_ovf",   bs_if.overflow, 1);
    cyc(0, 0, 1, '0);
    chk("clr_count", bs_if.count, 0);
    chk("clr_empty", bs_if.empty, 1);
    chk("clr_ovf",   bs_if.overflow, 0);

    // Asynchronous reset between edges in the middle of a burst.
    for (int i = 0; i < 5; i++) cyc(1, (i > 2), 0, 8'(8'h90 + i));
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_count", bs_if.count, 0);
    chk("arst_empty", bs_if.empty, 1);
    chk("arst_rv",    bs_if.rd_valid, 0);
    chk("arst_rd",    bs_if.rd_data, 0);
    chk("arst_fwft_rv", bf_if.rd_valid, 0);
    #1 rst = 1'b0;
    cyc(1, 0, 0, 8'h77);
    cyc(1, 0, 0, 8'h78);
    chk("arst_fwft_head", bf_if.rd_data, 8'h77);
    cyc(0, 1, 0, '0);
    chk("arst_first_read", bs_if.rd_data, 8'h77);

    // Randomised traffic with shifting read/write bias.
    for (int ph = 0; ph < 12; ph++) begin
      pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      pr = 100 - pw;
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 127) == 0, 8'($urandom));
      end
    end

    drive(0, 0, 0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
